// File: rtl/poly_phase_nco.sv
// Polyphase phase generator: LANES phase words per clock with a runtime
// increment/offset that is rebuilt in a shadow set and swapped in without touching acc.

module nco_lane #(
  parameter int PHASE_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] acc_i,
  input  logic [PHASE_W-1:0] mult_i,
  input  logic [PHASE_W-1:0] off_i,
  output logic [PHASE_W-1:0] phase_o
);
  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (en_i) phase_d = acc_i + mult_i + off_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign phase_o = phase_q;
endmodule

module poly_phase_nco #(
  parameter int                 LANES     = 4,
  parameter int                 PHASE_W   = 32,
  parameter logic [PHASE_W-1:0] INC_RESET = 32'h3333_3333
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic                     sync_clr_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [PHASE_W-1:0]       cfg_inc_i,
  input  logic [PHASE_W-1:0]       cfg_offset_i,
  output logic [LANES*PHASE_W-1:0] phase_o,
  output logic                     valid_o,
  output logic                     busy_o
);
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_APPLY} state_e;

  function automatic logic [LANES:0][PHASE_W-1:0] rst_set();
    logic [LANES:0][PHASE_W-1:0] r;
    r[0] = '0;
    for (int k = 1; k <= LANES; k++) r[k] = r[k-1] + INC_RESET;
    return r;
  endfunction

  localparam logic [LANES:0][PHASE_W-1:0] RST_SET = rst_set();

  state_e                      state_q, state_d;
  logic                        ready_q, ready_d;
  logic                        valid_q;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [PHASE_W-1:0]          acc_q, acc_d;
  logic [LANES:0][PHASE_W-1:0] mult_q, mult_d, smult_q, smult_d;
  logic [PHASE_W-1:0]          off_q, off_d, soff_q, soff_d, sinc_q, sinc_d;
  logic [LANES-1:0][PHASE_W-1:0] lane_ph;

  always_comb begin
    acc_d = acc_q;
    if (sync_clr_i)   acc_d = '0;
    else if (valid_i) acc_d = acc_q + mult_q[LANES];

    state_d = state_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    smult_d = smult_q;
    soff_d  = soff_q;
    sinc_d  = sinc_q;
    mult_d  = mult_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: if (cfg_valid_i) begin
        sinc_d     = cfg_inc_i;
        soff_d     = cfg_offset_i;
        smult_d[0] = '0;
        cnt_d      = CW'(1);
        state_d    = S_CALC;
        ready_d    = 1'b0;
      end
      S_CALC: begin
        // One adder reused across LANES cycles to build k*inc in the shadow set
        for (int j = 1; j <= LANES; j++)
          if (cnt_q == CW'(j)) smult_d[j] = smult_q[j-1] + sinc_q;
        if (cnt_q == CW'(LANES)) state_d = S_APPLY;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_APPLY: begin
        mult_d  = smult_q;
        off_d   = soff_q;
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mult_q  <= RST_SET;
      smult_q <= RST_SET;
      off_q   <= '0;
      soff_q  <= '0;
      sinc_q  <= INC_RESET;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_i;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mult_q  <= mult_d;
      smult_q <= smult_d;
      off_q   <= off_d;
      soff_q  <= soff_d;
      sinc_q  <= sinc_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    nco_lane #(.PHASE_W(PHASE_W)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (valid_i),
      .acc_i   (acc_q),
      .mult_i  (mult_q[k]),
      .off_i   (off_q),
      .phase_o (lane_ph[k])
    );
  end

  assign phase_o     = lane_ph;
  assign valid_o     = valid_q;
  assign cfg_ready_o = ready_q;
  assign busy_o      = ~ready_q;
endmodule

// File: tb/tb_poly_phase_nco.sv
// Directed bench for poly_phase_nco (LANES=4, PHASE_W=32) with a tiny phase model.

module tb_poly_phase_nco;
  localparam int L = 4;
  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           rst_i, valid_i, sync_clr_i, cfg_valid_i;
  logic [W-1:0]   cfg_inc_i, cfg_offset_i;
  logic           cfg_ready_o, valid_o, busy_o;
  logic [L*W-1:0] phase_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] m_acc, m_inc, m_off, e;

  poly_phase_nco #(.LANES(L), .PHASE_W(W), .INC_RESET(32'h3333_3333)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .sync_clr_i(sync_clr_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_inc_i(cfg_inc_i),
    .cfg_offset_i(cfg_offset_i), .phase_o(phase_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    logic [W-1:0] b1 [L];
    logic [W-1:0] b2 [L];
    b1 = '{32'h0, 32'h3333_3333, 32'h6666_6666, 32'h9999_9999};
    b2 = '{32'hCCCC_CCCC, 32'hFFFF_FFFF, 32'h3333_3332, 32'h6666_6665};
    rst_i = 1'b0; valid_i = 1'b0; sync_clr_i = 1'b0; cfg_valid_i = 1'b0;
    cfg_inc_i = '0; cfg_offset_i = '0;
    #12;
    total++; if (phase_o !== '0)     begin bad++; $display("FAIL rst_phase got=%h want=0", phase_o); end
    total++; if (valid_o !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b want=0", valid_o); end
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cfg_ready_o); end
    total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
    rst_i = 1'b1;
    tick;
    total++; if (valid_o !== 1'b0 || phase_o !== '0) begin bad++; $display("FAIL idle_after_rst got=%b/%h want=0/0", valid_o, phase_o); end
    valid_i = 1'b1;
    tick;
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL blk1_valid got=%b want=1", valid_o); end
    for (int k = 0; k < L; k++) begin
      total++; if (phase_o[k*W +: W] !== b1[k]) begin bad++; $display("FAIL blk1_lane%0d got=%h want=%h", k, phase_o[k*W +: W], b1[k]); end
    end
    tick;
    for (int k = 0; k < L; k++) begin
      total++; if (phase_o[k*W +: W] !== b2[k]) begin bad++; $display("FAIL blk2_lane%0d got=%h want=%h", k, phase_o[k*W +: W], b2[k]); end
    end
    m_acc = 32'h9999_9998; m_inc = 32'h3333_3333; m_off = '0;
  endtask

  task automatic test_config;
    int low;
    logic [W-1:0] a;
    logic [W-1:0] offs [L];
    offs = '{32'h4000_0000, 32'h4800_0000, 32'h5000_0000, 32'h5800_0000};
    cfg_inc_i = 32'h0800_0000; cfg_offset_i = 32'h4000_0000; cfg_valid_i = 1'b1;
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL cfg_ready_pre got=%b want=1", cfg_ready_o); end
    tick;
    cfg_valid_i = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL cfg_busy got=%b want=1", busy_o); end
    low = 0;
    while (1) begin
      for (int k = 0; k < L; k++) begin
        e = m_acc + W'(k) * m_inc + m_off;
        total++; if (phase_o[k*W +: W] !== e) begin bad++; $display("FAIL cfg_old_blk lane%0d got=%h want=%h", k, phase_o[k*W +: W], e); end
      end
      m_acc = m_acc + W'(L) * m_inc;
      if (cfg_ready_o !== 1'b0 || low >= 20) break;
      low++;
      tick;
    end
    total++; if (low !== 5) begin bad++; $display("FAIL cfg_busy_cycles got=%0d want=5", low); end
    a = m_acc;
    tick;
    for (int k = 0; k < L; k++) begin
      e = a + offs[k];
      total++; if (phase_o[k*W +: W] !== e) begin bad++; $display("FAIL cfg_new_blk lane%0d got=%h want=%h", k, phase_o[k*W +: W], e); end
    end
    m_inc = 32'h0800_0000; m_off = 32'h4000_0000; m_acc = a + 32'h2000_0000;
    tick;
    e = a + 32'h2000_0000 + 32'h4000_0000;
    total++; if (phase_o[W-1:0] !== e) begin bad++; $display("FAIL cfg_next_base got=%h want=%h", phase_o[W-1:0], e); end
    m_acc = m_acc + 32'h2000_0000;
  endtask

  task automatic test_clear;
    sync_clr_i = 1'b1;
    tick;
    sync_clr_i = 1'b0;
    for (int k = 0; k < L; k++) begin
      e = m_acc + W'(k) * m_inc + m_off;
      total++; if (phase_o[k*W +: W] !== e) begin bad++; $display("FAIL clr_same_cycle lane%0d got=%h want=%h", k, phase_o[k*W +: W], e); end
    end
    tick;
    total++; if (phase_o[W-1:0] !== 32'h4000_0000) begin bad++; $display("FAIL clr_lane0 got=%h want=40000000", phase_o[W-1:0]); end
    total++; if (phase_o[3*W +: W] !== 32'h5800_0000) begin bad++; $display("FAIL clr_lane3 got=%h want=58000000", phase_o[3*W +: W]); end
    m_acc = 32'h2000_0000;
  endtask

  task automatic test_busy_req;
    int n;
    valid_i = 1'b0;
    cfg_inc_i = 32'h0100_0000; cfg_offset_i = 32'h0; cfg_valid_i = 1'b1;
    tick;
    cfg_valid_i = 1'b0;
    tick;
    tick;
    cfg_inc_i = 32'h0F00_0000; cfg_offset_i = 32'h1234_5678; cfg_valid_i = 1'b1;
    total++; if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", cfg_ready_o); end
    tick;
    cfg_valid_i = 1'b0;
    n = 0;
    while (cfg_ready_o !== 1'b1 && n < 20) begin tick; n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL busy_timeout got=%0d want<20", n); end
    tick;
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL busy_second_req_taken got=%b want=1", cfg_ready_o); end
    m_inc = 32'h0100_0000; m_off = '0;
    valid_i = 1'b1;
    tick;
    for (int k = 0; k < L; k++) begin
      e = m_acc + W'(k) * m_inc + m_off;
      total++; if (phase_o[k*W +: W] !== e) begin bad++; $display("FAIL busy_active lane%0d got=%h want=%h", k, phase_o[k*W +: W], e); end
    end
    m_acc = m_acc + W'(L) * m_inc;
  endtask

  task automatic test_reset_mid_calc;
    logic [W-1:0] b1 [L];
    b1 = '{32'h0, 32'h3333_3333, 32'h6666_6666, 32'h9999_9999};
    cfg_inc_i = 32'h0200_0000; cfg_offset_i = 32'h0; cfg_valid_i = 1'b1;
    tick;
    cfg_valid_i = 1'b0;
    tick;
    tick;
    #2 rst_i = 1'b0;
    #1;
    total++; if (phase_o !== '0)       begin bad++; $display("FAIL midrst_phase got=%h want=0", phase_o); end
    total++; if (valid_o !== 1'b0)     begin bad++; $display("FAIL midrst_valid got=%b want=0", valid_o); end
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", cfg_ready_o); end
    total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
    #3 rst_i = 1'b1;
    tick;
    for (int k = 0; k < L; k++) begin
      total++; if (phase_o[k*W +: W] !== b1[k]) begin bad++; $display("FAIL midrst_blk1 lane%0d got=%h want=%h", k, phase_o[k*W +: W], b1[k]); end
    end
    m_acc = 32'hCCCC_CCCC; m_inc = 32'h3333_3333; m_off = '0;
  endtask

  task automatic test_hold;
    logic [L*W-1:0] held;
    tick;
    for (int k = 0; k < L; k++) held[k*W +: W] = m_acc + W'(k) * m_inc + m_off;
    total++; if (phase_o !== held) begin bad++; $display("FAIL hold_pre got=%h want=%h", phase_o, held); end
    m_acc = m_acc + W'(L) * m_inc;
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++; if (valid_o !== 1'b0 || phase_o !== held) begin bad++; $display("FAIL hold_cyc%0d got=%b/%h want=0/%h", i, valid_o, phase_o, held); end
    end
    valid_i = 1'b1;
    tick;
    for (int k = 0; k < L; k++) begin
      e = m_acc + W'(k) * m_inc + m_off;
      total++; if (phase_o[k*W +: W] !== e) begin bad++; $display("FAIL hold_resume lane%0d got=%h want=%h", k, phase_o[k*W +: W], e); end
    end
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL hold_resume_valid got=%b want=1", valid_o); end
  endtask

  initial begin
    test_reset;
    test_config;
    test_clear;
    test_busy_req;
    test_reset_mid_calc;
    test_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
